vga_sync_monitor: RTL and testbench

//  Receive-side counterpart of the vga640x480 timing generator: samples HS/VS on each pixel strobe,

---
 rtl/vga_sync_monitor_if.sv | 19 +
 rtl/vga_sync_monitor.sv | 214 +++++++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_monitor_if.sv
// vga_sync_monitor_if: sync bus observed by the VGA timing monitor.
// Master drives pix_stb/hs/vs (generator side); slave samples them (monitor).
interface vga_sync_monitor_if;
  logic pix_stb;
  logic hs;
  logic vs;

  modport master (
    output pix_stb,
    output hs,
    output vs
  );

  modport slave (
    input pix_stb,
    input hs,
    input vs
  );
endinterface

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: locks onto an HS/VS raster, recovers x/y/de and flags
// sync timing violations while locked.
//
// Ports:
//   CLK, RST_BTN       clock, async active-low reset
//   i_sync (slave)     pix_stb (1-CLK pixel strobe), hs, vs
//   o_x, o_y           recovered position of last strobe (0 in SEARCH)
//   o_de               locked and inside the visible area
//   o_locked           raster locked
//   o_frame_start      1-CLK pulse, locked position became (0,0)
//   o_err              1-CLK pulse, timing violation while locked
//   o_err_code         latched cause {vs_mis, hs_mis} of last error
//   o_frame_cnt        frames seen while locked (VGA_MON_STATS_EN)
//   o_err_cnt          saturating error count   (VGA_MON_STATS_EN)
// Option: define VGA_MON_STATS_EN to build the two statistics counters;
// otherwise both counter ports are tied to 0.
module vga_sync_monitor #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic                CLK,
  input  logic                RST_BTN,
  vga_sync_monitor_if.slave   i_sync,
  output logic [9:0]          o_x,
  output logic [9:0]          o_y,
  output logic                o_de,
  output logic                o_locked,
  output logic                o_frame_start,
  output logic                o_err,
  output logic [1:0]          o_err_code,
  output logic [15:0]         o_frame_cnt,
  output logic [7:0]          o_err_cnt
);

  localparam logic [9:0] H_LAST =
    10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST =
    10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END =
    10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END =
    10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] HA = 10'(H_ACTIVE);
  localparam logic [9:0] VA = 10'(V_ACTIVE);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nx;
  logic [9:0] r_h;
  logic [9:0] r_v;
  logic       r_vs_q;
  logic       r_de;
  logic       r_fs;
  logic       r_err;
  logic [1:0] r_err_code;

  logic       w_stb;
  logic       w_hs_act;
  logic       w_vs_act;
  logic       w_vs_rise;
  logic [9:0] w_h_nx;
  logic [9:0] w_v_nx;
  logic       w_exp_hs;
  logic       w_exp_vs;
  logic       w_hs_mis;
  logic       w_vs_mis;
  logic       w_mis;
  logic [9:0] w_h_d;
  logic [9:0] w_v_d;
  logic       w_fs;
  logic       w_err;

  assign w_stb     = i_sync.pix_stb;
  assign w_hs_act  = (i_sync.hs == HS_POL);
  assign w_vs_act  = (i_sync.vs == VS_POL);
  assign w_vs_rise = w_vs_act & ~r_vs_q;

  // Position this strobe should carry, given the last one.
  assign w_h_nx = (r_h == H_LAST) ? 10'd0 : r_h + 10'd1;
  assign w_v_nx = (r_h != H_LAST) ? r_v :
                  (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;

  assign w_exp_hs = (w_h_nx >= HS_BEG) && (w_h_nx <= HS_END);
  assign w_exp_vs = (w_v_nx >= VS_BEG) && (w_v_nx <= VS_END);
  assign w_hs_mis = w_hs_act != w_exp_hs;
  assign w_vs_mis = w_vs_act != w_exp_vs;
  assign w_mis    = w_hs_mis | w_vs_mis;

  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) r_state <= SEARCH;
    else          r_state <= w_state_nx;
  end

  // Position is kept at 0 whenever the FSM sits in SEARCH,
  // so o_x/o_y read 0 there without extra muxing.
  always_comb begin
    w_state_nx = r_state;
    w_h_d      = r_h;
    w_v_d      = r_v;
    w_fs       = 1'b0;
    w_err      = 1'b0;
    if (w_stb) begin
      unique case (r_state)
        SEARCH: begin
          if (w_vs_rise) begin
            w_h_d      = 10'd0;
            w_v_d      = VS_BEG;
            w_state_nx = ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (w_mis) begin
            w_h_d      = 10'd0;
            w_v_d      = 10'd0;
            w_state_nx = SEARCH;
          end else begin
            w_h_d = w_h_nx;
            w_v_d = w_v_nx;
            if (w_vs_rise && w_h_nx == 10'd0 &&
                w_v_nx == VS_BEG)
              w_state_nx = LOCKED;
          end
        end
        LOCKED: begin
          if (w_mis) begin
            w_h_d      = 10'd0;
            w_v_d      = 10'd0;
            w_err      = 1'b1;
            w_state_nx = SEARCH;
          end else begin
            w_h_d = w_h_nx;
            w_v_d = w_v_nx;
            w_fs  = (w_h_nx == 10'd0) && (w_v_nx == 10'd0);
          end
        end
        default: begin
          w_h_d      = 10'd0;
          w_v_d      = 10'd0;
          w_state_nx = SEARCH;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      r_h        <= 10'd0;
      r_v        <= 10'd0;
      r_vs_q     <= 1'b0;
      r_de       <= 1'b0;
      r_fs       <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
    end else if (w_stb) begin
      r_h    <= w_h_d;
      r_v    <= w_v_d;
      r_vs_q <= w_vs_act;
      r_de   <= (w_state_nx == LOCKED) &&
                (w_h_d < HA) && (w_v_d < VA);
      r_fs   <= w_fs;
      r_err  <= w_err;
      if (w_err) r_err_code <= {w_vs_mis, w_hs_mis};
    end else begin
      r_fs  <= 1'b0;
      r_err <= 1'b0;
    end
  end

`ifdef VGA_MON_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [7:0]  r_err_cnt;

  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      r_frame_cnt <= 16'd0;
      r_err_cnt   <= 8'd0;
    end else begin
      if (w_fs) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_err && r_err_cnt != 8'hFF)
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign o_frame_cnt = r_frame_cnt;
  assign o_err_cnt   = r_err_cnt;
`else
  assign o_frame_cnt = 16'd0;
  assign o_err_cnt   = 8'd0;
`endif

  assign o_x           = r_h;
  assign o_y           = r_v;
  assign o_de          = r_de;
  assign o_locked      = (r_state == LOCKED);
  assign o_frame_start = r_fs;
  assign o_err         = r_err;
  assign o_err_code    = r_err_code;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor: directed bench on a reduced 10x8 raster
// (H 6/1/2/1, V 4/1/2/1) so whole frames run in a few hundred clocks.
module tb_vga_sync_monitor;

  localparam int HA  = 6;
  localparam int HF  = 1;
  localparam int HSY = 2;
  localparam int HB  = 1;
  localparam int VA  = 4;
  localparam int VF  = 1;
  localparam int VSY = 2;
  localparam int VB  = 1;
  localparam int HT  = HA + HF + HSY + HB;
  localparam int VT  = VA + VF + VSY + VB;
  localparam int FRM = HT * VT;
  localparam int HSS = HA + HF;
  localparam int HSE = HA + HF + HSY - 1;
  localparam int VSS = VA + VF;
  localparam int VSE = VA + VF + VSY - 1;
`ifdef VGA_MON_STATS_EN
  localparam int N_ERR = 300;
`else
  localparam int N_ERR = 20;
`endif

  logic        CLK = 1'b0;
  logic        RST_BTN = 1'b0;
  logic [9:0]  o_x;
  logic [9:0]  o_y;
  logic        o_de;
  logic        o_locked;
  logic        o_frame_start;
  logic        o_err;
  logic [1:0]  o_err_code;
  logic [15:0] o_frame_cnt;
  logic [7:0]  o_err_cnt;

  vga_sync_monitor_if s ();

  vga_sync_monitor #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .CLK          (CLK),
    .RST_BTN      (RST_BTN),
    .i_sync       (s),
    .o_x          (o_x),
    .o_y          (o_y),
    .o_de         (o_de),
    .o_locked     (o_locked),
    .o_frame_start(o_frame_start),
    .o_err        (o_err),
    .o_err_code   (o_err_code),
    .o_frame_cnt  (o_frame_cnt),
    .o_err_cnt    (o_err_cnt)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;
  int gh = 0;
  int gv = 0;
  int err_seen = 0;
  int fs_seen = 0;

  always @(negedge CLK) begin
    if (o_err) err_seen++;
    if (o_frame_start) fs_seen++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Idle gap-1 clocks, then one strobe; returns 1ns after its edge.
  task automatic strobe(input logic ha, input logic va,
                        input int gap);
    repeat (gap - 1) begin
      @(posedge CLK);
      #1;
    end
    s.pix_stb = 1'b1;
    s.hs = ~ha;
    s.vs = ~va;
    @(posedge CLK);
    #1;
    s.pix_stb = 1'b0;
  endtask

  // Emit generator pixel (gh,gv); xh/xv force an extra active level.
  task automatic gen_px(input int gap, input logic xh,
                        input logic xv);
    logic ha;
    logic va;
    ha = (gh >= HSS && gh <= HSE) || xh;
    va = (gv >= VSS && gv <= VSE) || xv;
    strobe(ha, va, gap);
    gh++;
    if (gh == HT) begin
      gh = 0;
      gv++;
      if (gv == VT) gv = 0;
    end
  endtask

  task automatic run_to(input int h, input int v, input int gap);
    int n;
    n = 0;
    while (!(gh == h && gv == v) && n < 2 * FRM) begin
      gen_px(gap, 1'b0, 1'b0);
      n++;
    end
  endtask

  task automatic wait_lock(input int gap, input int budget);
    int n;
    n = 0;
    while (!o_locked && n < budget) begin
      gen_px(gap, 1'b0, 1'b0);
      n++;
    end
    chk("lock", o_locked, 1);
  endtask

  int e0;
  int f0;
  logic [9:0] xs;
  logic [9:0] ys;

  initial begin
    s.pix_stb = 1'b0;
    s.hs = 1'b1;
    s.vs = 1'b1;
    #23;
    chk("rst_locked", o_locked, 0);
    chk("rst_x", o_x, 0);
    chk("rst_y", o_y, 0);
    chk("rst_de", o_de, 0);
    chk("rst_fs", o_frame_start, 0);
    chk("rst_err", o_err, 0);
    chk("rst_code", o_err_code, 0);
    chk("rst_fcnt", o_frame_cnt, 0);
    chk("rst_ecnt", o_err_cnt, 0);
    @(posedge CLK);
    #1;
    RST_BTN = 1'b1;

    // Lock after the second VS leading edge
    run_to(0, VSS, 4);
    gen_px(4, 1'b0, 1'b0);
    chk("acq_locked", o_locked, 0);
    chk("acq_x", o_x, 0);
    chk("acq_y", o_y, VSS);
    run_to(0, VSS, 4);
    chk("prelock", o_locked, 0);
    gen_px(4, 1'b0, 1'b0);
    chk("lock2", o_locked, 1);
    chk("lock_y", o_y, VSS);

    // Visible-area boundary
    run_to(HA - 1, VA - 1, 4);
    gen_px(4, 1'b0, 1'b0);
    chk("de_in", o_de, 1);
    chk("x_in", o_x, HA - 1);
    chk("y_in", o_y, VA - 1);
    gen_px(4, 1'b0, 1'b0);
    chk("de_out", o_de, 0);

    // Frame start once per frame
    run_to(0, 0, 4);
    f0 = fs_seen;
    gen_px(4, 1'b0, 1'b0);
    chk("fs_pulse", o_frame_start, 1);
    run_to(0, 0, 4);
    chk("fs_once", fs_seen - f0, 1);

    // HS stretched by one pixel
    e0 = err_seen;
    run_to(HSE + 1, 1, 4);
    gen_px(4, 1'b1, 1'b0);
    chk("hs_err", o_err, 1);
    chk("hs_code", o_err_code, 2'b01);
    chk("hs_unlock", o_locked, 0);
    chk("hs_x0", o_x, 0);
    wait_lock(4, 3 * FRM);
    chk("hs_err_n", err_seen - e0, 1);

    // Dropped line: VS arrives one line early
    run_to(0, 1, 4);
    gv = 2;
    run_to(0, VSS, 4);
    gen_px(4, 1'b0, 1'b0);
    chk("vs_err", o_err, 1);
    chk("vs_code", o_err_code, 2'b10);
    chk("vs_unlock", o_locked, 0);
    wait_lock(4, 3 * FRM);

    // HS and VS both wrong on one strobe
    run_to(0, 1, 4);
    gen_px(4, 1'b1, 1'b1);
    chk("both_err", o_err, 1);
    chk("both_code", o_err_code, 2'b11);
    wait_lock(4, 3 * FRM);

    // Strobe held low while locked
    run_to(2, 2, 4);
    gen_px(4, 1'b0, 1'b0);
    xs = o_x;
    ys = o_y;
    e0 = err_seen;
    f0 = fs_seen;
    repeat (50) begin
      s.hs = 1'($urandom);
      s.vs = 1'($urandom);
      @(posedge CLK);
      #1;
    end
    chk("hold_x", o_x, 32'(xs));
    chk("hold_y", o_y, 32'(ys));
    chk("hold_lock", o_locked, 1);
    chk("hold_err", err_seen - e0, 0);
    chk("hold_fs", fs_seen - f0, 0);
    repeat (5) gen_px(4, 1'b0, 1'b0);
    chk("hold_after", o_locked, 1);

    // Async reset mid-frame
    run_to(3, 2, 4);
    gen_px(4, 1'b0, 1'b0);
    RST_BTN = 1'b0;
    #2;
    chk("ar_locked", o_locked, 0);
    chk("ar_x", o_x, 0);
    chk("ar_y", o_y, 0);
    chk("ar_de", o_de, 0);
    chk("ar_code", o_err_code, 0);
    chk("ar_fcnt", o_frame_cnt, 0);
    chk("ar_ecnt", o_err_cnt, 0);
    @(posedge CLK);
    #1;
    RST_BTN = 1'b1;
    e0 = err_seen;
    wait_lock(4, 3 * FRM);
    chk("ar_noerr", err_seen - e0, 0);
    chk("ar_fcnt0", o_frame_cnt, 0);

    // Statistics: 3 clean frames, then repeated errors
    repeat (3) begin
      gen_px(1, 1'b0, 1'b0);
      run_to(0, VSS, 1);
    end
    gen_px(1, 1'b0, 1'b0);
    e0 = err_seen;
    for (int i = 0; i < N_ERR; i++) begin
      gen_px(1, 1'b1, 1'b0);
      wait_lock(1, 3 * FRM);
    end
    chk("st_err_n", err_seen - e0, N_ERR);
`ifdef VGA_MON_STATS_EN
    chk("st_fcnt", o_frame_cnt, 3);
    chk("st_ecnt", o_err_cnt, 255);
`else
    chk("st_fcnt", o_frame_cnt, 0);
    chk("st_ecnt", o_err_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
